iob_cache_traffic_gen: RTL and testbench

- Self-checking IOb manager that sits directly upstream of the cache front end in the cache simulation UUT.
- Drives the cache's IOb subordinate port: writes an LFSR data pattern over a word range, reads the range back, compares each returned word and reports error statistics.
- Exercises the full path: cache fill, eviction and back-end AXI traffic into the external memory model.

---
 rtl/iob_cache_traffic_gen.sv | 151 +++++++++++++++
 tb/tb_iob_cache_traffic_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_traffic_gen.sv
// IOb manager that writes an LFSR pattern over a word range, reads it back
// and reports mismatch statistics. Drives the cache front-end subordinate port.
module iob_cache_traffic_gen #(
  parameter int          ADDR_W   = 24,
  parameter int          NWORDS_W = 6,
  parameter logic [31:0] SEED     = 32'hACE1_2345
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_cnt_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [31:0]       iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic              iob_rvalid_i,
  input  logic [31:0]       iob_rdata_i,
  input  logic              iob_ready_i
);

  localparam int N = 1 << NWORDS_W;

  // Handshake: a request transfers on any enabled cycle with valid&ready;
  // while valid is high and ready low, addr/wdata/wstrb hold stable.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NWORDS_W-1:0] req_idx_q, req_idx_d;
  logic [NWORDS_W:0]   rcv_idx_q, rcv_idx_d;
  logic [31:0]         wr_lfsr_q, wr_lfsr_d;
  logic [31:0]         chk_lfsr_q, chk_lfsr_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;

  logic              accept;
  logic              last_req;
  logic              rx;
  logic              last_rx;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] rcv_addr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'hA300_0000 : 32'h0);
  endfunction

  assign accept   = iob_valid_o && iob_ready_i;
  assign last_req = (req_idx_q == NWORDS_W'(N - 1));
  assign rx       = iob_rvalid_i && ((state_q == S_READ) || (state_q == S_DRAIN));
  assign last_rx  = (rcv_idx_q == (NWORDS_W + 1)'(N - 1));
  // Address arithmetic stays in ADDR_W bits so the word range wraps.
  assign req_addr = base_q + (ADDR_W'(req_idx_q) << 2);
  assign rcv_addr = base_q + (ADDR_W'(rcv_idx_q[NWORDS_W-1:0]) << 2);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    req_idx_d   = req_idx_q;
    rcv_idx_d   = rcv_idx_q;
    wr_lfsr_d   = wr_lfsr_q;
    chk_lfsr_d  = chk_lfsr_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          base_d      = base_addr_i & ~ADDR_W'(3);
          req_idx_d   = '0;
          rcv_idx_d   = '0;
          wr_lfsr_d   = SEED;
          chk_lfsr_d  = SEED;
          err_cnt_d   = '0;
          first_err_d = '0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          wr_lfsr_d = lfsr_step(wr_lfsr_q);
          req_idx_d = req_idx_q + NWORDS_W'(1);
          if (last_req) state_d = S_READ;
        end
      end
      S_READ: begin
        if (accept) begin
          req_idx_d = req_idx_q + NWORDS_W'(1);
          if (last_req) state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    // Read returns are checked in READ and DRAIN; the last one ends the run
    // even when it coincides with the last read accept.
    if (rx) begin
      chk_lfsr_d = lfsr_step(chk_lfsr_q);
      rcv_idx_d  = rcv_idx_q + (NWORDS_W + 1)'(1);
      if (iob_rdata_i != chk_lfsr_q) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0) first_err_d = rcv_addr;
      end
      if (last_rx) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      req_idx_q   <= '0;
      rcv_idx_q   <= '0;
      wr_lfsr_q   <= SEED;
      chk_lfsr_q  <= SEED;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else if (cke_i) begin
      state_q     <= state_d;
      base_q      <= base_d;
      req_idx_q   <= req_idx_d;
      rcv_idx_q   <= rcv_idx_d;
      wr_lfsr_q   <= wr_lfsr_d;
      chk_lfsr_q  <= chk_lfsr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign busy_o           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = done_o && (err_cnt_q == 16'd0);
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign iob_valid_o      = (state_q == S_WRITE) || (state_q == S_READ);
  assign iob_addr_o       = iob_valid_o ? req_addr : '0;
  assign iob_wdata_o      = (state_q == S_WRITE) ? wr_lfsr_q : 32'h0;
  assign iob_wstrb_o      = (state_q == S_WRITE) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_iob_cache_traffic_gen.sv
// Bench for iob_cache_traffic_gen: two instances (4 and 16 words), each behind
// an in-order IOb memory model with random latency and optional read corruption.
module tb_iob_cache_traffic_gen;

  localparam int          ADDR_W = 24;
  localparam logic [31:0] SEED   = 32'hACE1_2345;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              pass;
    logic              valid;
    logic [15:0]       err;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    int                xfers;
    int                pend;
  } obs_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic cke   = 1'b1;

  // per-instance stimulus and run configuration, written only by the main process
  logic              start      [2];
  logic [ADDR_W-1:0] base       [2];
  int                ready_mode [2];
  int                lat_max    [2];
  int                mem_mode   [2];   // 0 ideal, 1 flip bit0 at bad_addr, 2 all zero
  logic [ADDR_W-1:0] bad_addr   [2];
  logic [ADDR_W-1:0] cfg_base   [2];
  int                nwords     [2];
  int                arm_seq    [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_at(input int i);
    logic [31:0] l;
    l = SEED;
    for (int s = 0; s < i; s++) l = {1'b0, l[31:1]} ^ (l[0] ? 32'hA300_0000 : 32'h0);
    return l;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b, input int i);
    longint a;
    a = (longint'(b) / 4) * 4 + 4 * longint'(i);
    return ADDR_W'(a % (longint'(1) << ADDR_W));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int NW = (g == 0) ? 2 : 4;
    logic              busy, done, pass, valid;
    logic              rvalid = 1'b0;
    logic              ready  = 1'b0;
    logic [31:0]       rdata  = 32'h0;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] first_err, addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [56:0]       exp_q[$];   // {is_write, addr, wdata}
    logic [63:0]       rd_q[$];    // {due_cycle, data}
    logic [31:0]       mem [int];
    int                ncyc  = 0;
    int                seen  = 0;
    int                xfers = 0;
    int                pend  = 0;
    logic              held  = 1'b0;
    logic [ADDR_W-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic [3:0]        h_wstrb;
    obs_t              obs;

    iob_cache_traffic_gen #(.ADDR_W(ADDR_W), .NWORDS_W(NW), .SEED(SEED)) u_dut (
      .clk_i            (clk),
      .cke_i            (cke),
      .arst_n_i         (rst_n),
      .start_i          (start[g]),
      .base_addr_i      (base[g]),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .err_cnt_o        (err_cnt),
      .first_err_addr_o (first_err),
      .iob_valid_o      (valid),
      .iob_addr_o       (addr),
      .iob_wdata_o      (wdata),
      .iob_wstrb_o      (wstrb),
      .iob_rvalid_i     (rvalid),
      .iob_rdata_i      (rdata),
      .iob_ready_i      (ready)
    );

    assign obs = '{busy: busy, done: done, pass: pass, valid: valid, err: err_cnt,
                   first: first_err, addr: addr, wdata: wdata, wstrb: wstrb,
                   xfers: xfers, pend: pend};

    // memory model + scoreboard, evaluated mid-cycle for the next rising edge
    always @(negedge clk) begin
      logic [56:0]       e;
      logic [31:0]       d;
      logic [ADDR_W-1:0] a;
      ncyc++;
      if (!rst_n) begin
        exp_q.delete();
        rd_q.delete();
        held   = 1'b0;
        rvalid = 1'b0;
        ready  = 1'b0;
      end else begin
        if (seen != arm_seq[g]) begin
          seen = arm_seq[g];
          for (int i = 0; i < nwords[g]; i++)
            exp_q.push_back({1'b1, word_addr(cfg_base[g], i), lfsr_at(i)});
          for (int i = 0; i < nwords[g]; i++)
            exp_q.push_back({1'b0, word_addr(cfg_base[g], i), 32'h0});
        end
        if (held) begin
          check("stall_addr", 32'(addr), 32'(h_addr));
          check("stall_wdata", wdata, h_wdata);
          check("stall_wstrb", 32'(wstrb), 32'(h_wstrb));
        end
        rvalid = 1'b0;
        if (cke && rd_q.size() > 0 && rd_q[0][63:32] <= 32'(ncyc)) begin
          d = rd_q[0][31:0];
          void'(rd_q.pop_front());
          rvalid = 1'b1;
          rdata  = d;
        end
        case (ready_mode[g])
          0:       ready = 1'b1;
          1:       ready = (ncyc % 3 == 0);
          default: ready = 1'($urandom_range(0, 1));
        endcase
        if (cke && valid && ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            check("xfer_extra", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("xfer_wstrb", 32'(wstrb), e[56] ? 32'hF : 32'h0);
            check("xfer_addr", 32'(addr), 32'(e[55:32]));
            if (e[56]) begin
              check("xfer_wdata", wdata, e[31:0]);
              mem[int'(addr)] = wdata;
            end else begin
              a = addr;
              d = mem.exists(int'(a)) ? mem[int'(a)] : 32'hDEAD_BEEF;
              if (mem_mode[g] == 1 && a == bad_addr[g]) d = d ^ 32'h1;
              else if (mem_mode[g] == 2) d = 32'h0;
              rd_q.push_back({32'(ncyc) + $urandom_range(1, lat_max[g]), d});
            end
          end
        end
        held    = valid && !(cke && ready);
        h_addr  = addr;
        h_wdata = wdata;
        h_wstrb = wstrb;
      end
      pend = exp_q.size() + rd_q.size();
    end
  end

  function automatic obs_t snap(input int k);
    if (k == 0) return g_inst[0].obs;
    return g_inst[1].obs;
  endfunction

  // reference result: which returned words differ from the pattern word i
  task automatic expect_result(input int k, output logic [15:0] err, output logic [ADDR_W-1:0] first);
    logic [ADDR_W-1:0] a;
    logic [31:0]       data, ret;
    err   = 16'd0;
    first = '0;
    for (int i = 0; i < nwords[k]; i++) begin
      a    = word_addr(cfg_base[k], i);
      data = lfsr_at(i);
      ret  = data;
      if (mem_mode[k] == 2) ret = 32'h0;
      else if (mem_mode[k] == 1 && a == bad_addr[k]) ret = data ^ 32'h1;
      if (ret != data) begin
        if (err == 16'd0) first = a;
        if (err != 16'hFFFF) err++;
      end
    end
  endtask

  // driver: call at posedge+1; returns at posedge+1 after the start edge
  task automatic launch(input int k, input logic [ADDR_W-1:0] b, input int rmode,
                        input int lat, input int mmode, input logic [ADDR_W-1:0] bad);
    obs_t o;
    ready_mode[k] = rmode;
    lat_max[k]    = lat;
    mem_mode[k]   = mmode;
    bad_addr[k]   = bad;
    cfg_base[k]   = b;
    nwords[k]     = (k == 0) ? 4 : 16;
    arm_seq[k]++;
    start[k] = 1'b1;
    base[k]  = b;
    @(posedge clk); #1;
    start[k] = 1'b0;
    base[k]  = ADDR_W'($urandom);
    o = snap(k);
    check("start_busy", 32'(o.busy), 32'd1);
    check("start_done_clr", 32'(o.done), 32'd0);
  endtask

  task automatic finish_run(input int k, input int x0, output int cyc);
    obs_t              o;
    logic [15:0]       ee;
    logic [ADDR_W-1:0] ef;
    cyc = 1;
    o = snap(k);
    while (!o.done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      o = snap(k);
    end
    check("done", 32'(o.done), 32'd1);
    expect_result(k, ee, ef);
    check("err_cnt", 32'(o.err), 32'(ee));
    check("first_err_addr", 32'(o.first), 32'(ef));
    check("pass", 32'(o.pass), 32'(ee == 16'd0));
    check("done_busy", 32'(o.busy), 32'd0);
    check("done_valid", 32'(o.valid), 32'd0);
    check("pending", 32'(o.pend), 32'd0);
    check("xfer_count", 32'(o.xfers - x0), 32'(2 * nwords[k]));
  endtask

  task automatic run(input int k, input logic [ADDR_W-1:0] b, input int rmode, input int lat,
                     input int mmode, input logic [ADDR_W-1:0] bad, output int cyc);
    obs_t o;
    o = snap(k);
    launch(k, b, rmode, lat, mmode, bad);
    finish_run(k, o.xfers, cyc);
  endtask

  initial begin
    obs_t              o;
    int                cyc, x0, k, mm;
    logic [ADDR_W-1:0] a0, b, bad;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; base[i] = '0; ready_mode[i] = 0; lat_max[i] = 1;
      mem_mode[i] = 0; bad_addr[i] = '0; cfg_base[i] = '0; nwords[i] = 0; arm_seq[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      o = snap(i);
      check("rst_busy", 32'(o.busy), 32'd0);
      check("rst_done", 32'(o.done), 32'd0);
      check("rst_pass", 32'(o.pass), 32'd0);
      check("rst_err", 32'(o.err), 32'd0);
      check("rst_first", 32'(o.first), 32'd0);
      check("rst_valid", 32'(o.valid), 32'd0);
      check("rst_addr", 32'(o.addr), 32'd0);
      check("rst_wdata", o.wdata, 32'd0);
      check("rst_wstrb", 32'(o.wstrb), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ideal memory, ready always high, 1-cycle latency
    run(0, 24'h100, 0, 1, 0, '0, cyc);
    check("ideal_cycles", 32'(cyc), 32'd10);
    @(posedge clk); #1;

    // ready toggling 1,0,0
    run(0, 24'h100, 1, 1, 0, '0, cyc);
    @(posedge clk); #1;

    // one corrupted word
    run(0, 24'h100, 0, 1, 1, 24'h108, cyc);
    @(posedge clk); #1;

    // all-zero returns, 16 words
    run(1, 24'h2000, 0, 2, 2, '0, cyc);
    @(posedge clk); #1;

    // reset while reads are in flight
    o = snap(0);
    x0 = o.xfers;
    launch(0, 24'h100, 0, 3, 0, '0);
    cyc = 0;
    o = snap(0);
    while (o.xfers - x0 < 6 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      o = snap(0);
    end
    check("rst_reach_read", 32'(o.xfers - x0 >= 6), 32'd1);
    rst_n = 1'b0;
    #1;
    o = snap(0);
    check("midrst_valid", 32'(o.valid), 32'd0);
    check("midrst_busy", 32'(o.busy), 32'd0);
    check("midrst_done", 32'(o.done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(0, 24'h100, 0, 1, 0, '0, cyc);
    check("rerun_cycles", 32'(cyc), 32'd10);
    @(posedge clk); #1;

    // start pulse during WRITE, then clock enable low for 5 cycles
    o = snap(0);
    x0 = o.xfers;
    launch(0, 24'h200, 0, 2, 0, '0);
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    cke = 1'b0;
    o = snap(0);
    a0 = o.addr;
    check("cke_in_write", 32'(o.valid && o.wstrb == 4'hF), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      o = snap(0);
      check("cke_addr_frozen", 32'(o.addr), 32'(a0));
    end
    cke = 1'b1;
    finish_run(0, x0, cyc);
    @(posedge clk); #1;

    // address wrap at the top of the space
    run(0, 24'hFFFFF8, 0, 1, 1, 24'h000004, cyc);
    @(posedge clk); #1;

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      k   = int'($urandom_range(0, 1));
      b   = ADDR_W'($urandom);
      mm  = int'($urandom_range(0, 2));
      bad = word_addr(b, int'($urandom_range(0, (k == 0) ? 3 : 15)));
      run(k, b, 2, int'($urandom_range(1, 4)), mm, bad, cyc);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
